// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: display geometry and
// the active-high segment codes, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;

  // Entry n is the pattern for hex value n (0-9, A, b, C, d, E, F).
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-digit to seven-segment lookup (active-high, {g..a}).
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         segs
);

  always_comb begin
    segs = SEG_CODES[digit];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver: per-frame snapshot of the digit
// word, one digit per slot, with a blanking window at the start of each slot.
module seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digit_ctrl,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  output logic [7:0]                    seg,
  output logic [NUM_DIGITS-1:0]         sel,
  output logic                          frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [2:0]            LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]                div_cnt;
  logic [2:0]                      idx;
  logic [NUM_DIGITS*DIGIT_W-1:0]   snap_digits;
  logic [NUM_DIGITS-1:0]           snap_dp;
  logic                            slot_tick;
  logic                            frame_load;
  logic                            blank;
  logic [DIGIT_W-1:0]              cur_digit;
  logic [6:0]                      cur_code;
  logic [7:0]                      seg_next;
  logic [NUM_DIGITS-1:0]           sel_next;

  assign slot_tick  = (div_cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_load = slot_tick && (idx == LAST_IDX);
  assign blank      = (int'(div_cnt) < BLANK_CYC);
  assign cur_digit  = snap_digits[DIGIT_W*idx +: DIGIT_W];

  seg7_decoder u_decoder (
    .digit (cur_digit),
    .segs  (cur_code)
  );

  // Polarity is folded in after the dp bit joins the decoded pattern.
  always_comb begin
    seg_next = SEG_OFF;
    sel_next = SEL_OFF;
    if (!blank) begin
      sel_next = SEL_OFF ^ (NUM_DIGITS'(1) << idx);
      seg_next = SEG_OFF ^ {snap_dp[idx], cur_code};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= slot_tick ? '0 : div_cnt + 1'b1;
      if (slot_tick) begin
        idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
      end
    end
  end

  // Inputs are only sampled at the end of the last slot, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
    end else if (frame_load) begin
      snap_digits <= digit_ctrl;
      snap_dp     <= dp_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      sel        <= SEL_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_next;
      sel        <= sel_next;
      frame_tick <= frame_load;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-count based reference model checked every
// cycle, plus hand-computed directed expectations.
module tb_seg_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 6 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] digit_ctrl = '0;
  logic [5:0]  dp_mask = '0;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  seg_scan_driver #(
    .SCAN_DIV       (SD),
    .BLANK_CYC      (BC),
    .SEG_ACTIVE_LOW (1),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_ctrl (digit_ctrl),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .sel        (sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] code_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: k = clock edges since reset release; the snapshot the
  // outputs of edge k were built from, and the snapshot held after it.
  int          k;
  logic [23:0] m_snap, m_used;
  logic [5:0]  m_dp, m_used_dp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= 0;
      m_snap    <= '0;
      m_dp      <= '0;
      m_used    <= '0;
      m_used_dp <= '0;
    end else begin
      k         <= k + 1;
      m_used    <= m_snap;
      m_used_dp <= m_dp;
      if ((k + 1) % FRAME == 0) begin
        m_snap <= digit_ctrl;
        m_dp   <= dp_mask;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [7:0] e_seg;
    logic [5:0] e_sel;
    logic       e_ft;
    int         d, slot;
    e_seg = 8'hFF;
    e_sel = 6'h3F;
    e_ft  = 1'b0;
    if (k > 0) begin
      d    = (k - 1) % SD;
      slot = ((k - 1) / SD) % 6;
      e_ft = (k % FRAME == 0);
      if (d >= BC) begin
        e_sel = ~(6'b1 << slot);
        e_seg = ~{m_used_dp[slot], code_tab[m_used[4*slot +: 4]]};
      end
    end
    check("model_seg", 32'(seg), 32'(e_seg));
    check("model_sel", 32'(sel), 32'(e_sel));
    check("model_frame_tick", 32'(frame_tick), 32'(e_ft));
    check("sel_onehot", 32'($countones(~sel) <= 1), 32'd1);
    if (sel == 6'h3F) check("dark_when_unselected", 32'(seg), 32'hFF);
  end

  task automatic wait_k(input int target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (k != target && n < 2000);
    if (k != target) begin
      errors++;
      checks++;
      $display("FAIL wait_k: edge count %0d never reached %0d", k, target);
    end
  endtask

  task automatic slot_check(input string name, input int frame, input int slot,
                            input logic [7:0] e_seg);
    wait_k(frame * FRAME + slot * SD + BC + 1);
    check({name, "_seg"}, 32'(seg), 32'(e_seg));
    check({name, "_sel"}, 32'(sel), 32'(~(6'b1 << slot) & 6'h3F));
  endtask

  logic [7:0] hex_exp [6] = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  initial begin
    int first;
    // Reset held low.
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_sel", 32'(sel), 32'h3F);
    check("rst_ft", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;

    // First active select three edges after release.
    first = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      @(negedge clk);
      if (sel != 6'h3F) first = k;
    end
    check("first_active_edge", 32'(first), 32'd3);
    check("zero_frame_seg", 32'(seg), 32'hC0);

    // Frame 0 shows zeros; new word snapshotted at edge 48.
    digit_ctrl = 24'h543210;
    dp_mask    = 6'b0;
    slot_check("zero_slot4", 0, 4, 8'hC0);
    wait_k(FRAME - 1);
    check("ft_before", 32'(frame_tick), 32'h0);
    wait_k(FRAME);
    check("ft_pulse", 32'(frame_tick), 32'h1);
    slot_check("f1_slot0", 1, 0, 8'hC0);
    slot_check("f1_slot1", 1, 1, 8'hF9);

    // Change during slot 2: frame 1 keeps old values.
    wait_k(FRAME + 2 * SD + 4);
    digit_ctrl = 24'h999999;
    slot_check("f1_slot3_old", 1, 3, 8'hB0);
    slot_check("f1_slot5_old", 1, 5, 8'h92);
    wait_k(2 * FRAME);
    check("ft_pulse2", 32'(frame_tick), 32'h1);
    slot_check("f2_slot0_new", 2, 0, 8'h90);

    // Hex digits.
    digit_ctrl = 24'hFEDCBA;
    for (int i = 0; i < 6; i++) slot_check("hex", 3, i, hex_exp[i]);

    // Decimal point on digit 2 only.
    digit_ctrl = 24'h888888;
    dp_mask    = 6'b000100;
    for (int i = 0; i < 6; i++) slot_check("dp", 4, i, (i == 2) ? 8'h00 : 8'h80);

    // Asynchronous reset mid-slot at idx 3.
    wait_k(5 * FRAME + 3 * SD + 4);
    check("pre_rst_sel", 32'(sel), 32'h37);
    #2 rst_n = 1'b0;
    #1;
    check("async_seg", 32'(seg), 32'hFF);
    check("async_sel", 32'(sel), 32'h3F);
    check("async_ft", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_k(BC + 1);
    check("restart_sel", 32'(sel), 32'h3E);
    check("restart_seg", 32'(seg), 32'hC0);
    wait_k(SD + BC + 1);
    check("restart_slot1_sel", 32'(sel), 32'h3D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
